// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key event receiver.
//   - Set-2 prefix codes (break, extend, pause) and modifier scan codes
//   - Keyboard response bytes that never produce a key event
//   - Event word layout and width
//   - Decoder FSM state type
package ps2_pkg;

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXTEND = 8'hE0;
  localparam logic [7:0] CODE_PAUSE  = 8'hE1;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;  // left plain, right with E0
  localparam logic [7:0] CODE_ALT    = 8'h11;  // left plain, right with E0
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_ECHO     = 8'hEE;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_DIAG_ERR = 8'hFD;
  localparam logic [7:0] RSP_ERR_00   = 8'h00;
  localparam logic [7:0] RSP_ERR_FF   = 8'hFF;

  // Pause is E1 followed by seven more bytes that carry no extra meaning.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int EVENT_WIDTH = 14;
  localparam int EV_EXT      = 8;
  localparam int EV_REL      = 9;
  localparam int EV_SHIFT    = 10;
  localparam int EV_CTRL     = 11;
  localparam int EV_ALT      = 12;
  localparam int EV_CAPS     = 13;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK,
    DEC_PAUSE
  } dec_state_e;

  function automatic logic is_swallowed(input logic [7:0] code);
    return code inside {RSP_BAT_OK, RSP_ACK, RSP_ECHO, RSP_BAT_FAIL,
                        RSP_DIAG_ERR, RSP_ERR_00, RSP_ERR_FF};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 byte receiver in the system clock domain.
//   clk, rst        system clock, asynchronous active-low reset
//   ps2_clk_i       raw PS/2 clock pin
//   ps2_data_i      raw PS/2 data pin
//   byte_valid_o    one-cycle pulse, byte_o holds a correctly framed byte
//   byte_o          received byte
//   err_o           one-cycle pulse on start, parity, stop or timeout error
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   fall_q;
  logic                   data_smp_q;
  logic [3:0]             bit_cnt_q;
  logic [TW-1:0]          timer_q;
  logic [7:0]             shift_q;
  logic                   parity_q;
  logic                   byte_valid_q;
  logic                   err_q;

  // Synchronisers idle high like the bus, so reset never fakes a falling edge.
  // fall_q and data_smp_q come out of the same stage, so data is sampled
  // exactly at the detected edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      data_smp_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      data_smp_q  <= data_sync_q[SYNC_STAGES-1];
    end
  end

  // bit_cnt_q: 0 waits for start, 1..8 data, 9 parity, 10 stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q    <= 4'd0;
      timer_q      <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (fall_q) begin
        timer_q <= '0;
        if (bit_cnt_q == 4'd0) begin
          if (data_smp_q) err_q <= 1'b1;
          else            bit_cnt_q <= 4'd1;
        end else if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= 4'd0;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (data_smp_q && (^{shift_q, parity_q})) byte_valid_q <= 1'b1;
          else                                       err_q        <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (timer_q == TW'(TIMEOUT_CYCLES)) begin
          err_q     <= 1'b1;
          bit_cnt_q <= 4'd0;
          timer_q   <= '0;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fall_q) begin
      if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd8) shift_q <= {data_smp_q, shift_q[7:1]};
      if (bit_cnt_q == 4'd9) parity_q <= data_smp_q;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = shift_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 Set-2 keyboard receiver producing buffered key events.
//   clk, rst      system clock, asynchronous active-low reset
//   ps2_clk       raw PS/2 clock pin
//   ps2_data      raw PS/2 data pin
//   event_ready   consumer accepts the head event
//   clr_status    one-cycle pulse clearing overflow / frame_err
//   event_valid   event FIFO is non-empty
//   event_data    head event: code, ext, rel, shift, ctrl, alt, caps_lock
//   fifo_count    FIFO occupancy
//   overflow      sticky, an event was dropped because the FIFO was full
//   frame_err     sticky, a PS/2 framing or timeout error was seen
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        event_ready,
  input  logic                        clr_status,
  output logic                        event_valid,
  output logic [EVENT_WIDTH-1:0]      event_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       rx_vld;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_valid_o(rx_vld),
    .byte_o      (rx_byte),
    .err_o       (rx_err)
  );

  dec_state_e state_q;
  logic [2:0] skip_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DEC_IDLE;
      skip_q  <= 3'd0;
    end else if (rx_vld) begin
      unique case (state_q)
        DEC_IDLE: begin
          if (rx_byte == CODE_EXTEND)     state_q <= DEC_EXT;
          else if (rx_byte == CODE_BREAK) state_q <= DEC_BRK;
          else if (rx_byte == CODE_PAUSE) begin
            state_q <= DEC_PAUSE;
            skip_q  <= PAUSE_SKIP;
          end
        end
        DEC_EXT:     state_q <= (rx_byte == CODE_BREAK) ? DEC_EXT_BRK : DEC_IDLE;
        DEC_BRK,
        DEC_EXT_BRK: state_q <= DEC_IDLE;
        DEC_PAUSE: begin
          skip_q <= skip_q - 3'd1;
          if (skip_q == 3'd1) state_q <= DEC_IDLE;
        end
        default:     state_q <= DEC_IDLE;
      endcase
    end
  end

  logic       key_ev, key_ext, key_rel, key_repeat, key_accept;
  logic [7:0] key_code;
  logic       lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q;
  logic       lshift_d, rshift_d, lctrl_d, rctrl_d, lalt_d, ralt_d, caps_d;
  logic       last_vld_q, last_ext_q;
  logic [7:0] last_code_q;
  logic [EVENT_WIDTH-1:0] ev_d;

  // Classify the incoming byte against the current decoder state, then apply
  // the repeat filter and the modifier updates the event implies.
  always_comb begin
    key_ev   = 1'b0;
    key_ext  = 1'b0;
    key_rel  = 1'b0;
    key_code = rx_byte;
    if (rx_vld) begin
      unique case (state_q)
        DEC_IDLE:    key_ev = !(rx_byte inside {CODE_EXTEND, CODE_BREAK, CODE_PAUSE})
                              && !is_swallowed(rx_byte);
        DEC_EXT: begin
          key_ev  = (rx_byte != CODE_BREAK);
          key_ext = 1'b1;
        end
        DEC_BRK: begin
          key_ev  = 1'b1;
          key_rel = 1'b1;
        end
        DEC_EXT_BRK: begin
          key_ev  = 1'b1;
          key_ext = 1'b1;
          key_rel = 1'b1;
        end
        DEC_PAUSE: begin
          key_ev   = (skip_q == 3'd1);
          key_code = CODE_PAUSE;
        end
        default: key_ev = 1'b0;
      endcase
    end

    key_repeat = (FILTER_REPEAT != 0) && !key_rel && last_vld_q &&
                 (last_code_q == key_code) && (last_ext_q == key_ext);
    key_accept = key_ev && !key_repeat;

    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    lalt_d   = lalt_q;
    ralt_d   = ralt_q;
    caps_d   = caps_q;
    if (key_accept) begin
      if (key_code == CODE_LSHIFT && !key_ext) lshift_d = !key_rel;
      if (key_code == CODE_RSHIFT && !key_ext) rshift_d = !key_rel;
      if (key_code == CODE_CTRL) begin
        if (key_ext) rctrl_d = !key_rel;
        else         lctrl_d = !key_rel;
      end
      if (key_code == CODE_ALT) begin
        if (key_ext) ralt_d = !key_rel;
        else         lalt_d = !key_rel;
      end
      if (key_code == CODE_CAPS && !key_ext && !key_rel) caps_d = !caps_q;
    end

    ev_d           = '0;
    ev_d[7:0]      = key_code;
    ev_d[EV_EXT]   = key_ext;
    ev_d[EV_REL]   = key_rel;
    ev_d[EV_SHIFT] = lshift_d | rshift_d;
    ev_d[EV_CTRL]  = lctrl_d | rctrl_d;
    ev_d[EV_ALT]   = lalt_d | ralt_d;
    ev_d[EV_CAPS]  = caps_d;
  end

  logic                   emit_q;
  logic [EVENT_WIDTH-1:0] emit_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q} <= '0;
      last_vld_q  <= 1'b0;
      last_ext_q  <= 1'b0;
      last_code_q <= 8'd0;
      emit_q      <= 1'b0;
    end else begin
      {lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q} <=
        {lshift_d, rshift_d, lctrl_d, rctrl_d, lalt_d, ralt_d, caps_d};
      emit_q <= key_accept;
      if (key_accept) begin
        last_vld_q  <= !key_rel;
        last_ext_q  <= key_ext;
        last_code_q <= key_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (key_accept) emit_data_q <= ev_d;
  end

  // Event FIFO with a registered head: event_data_q is loaded with whatever
  // will be at the head after this cycle's push/pop.
  logic [EVENT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          rd_q, wr_q, rd_d;
  logic [CW-1:0]          count_q, count_d, remain;
  logic                   valid_q, pop, full, push_ok, ovf_set;
  logic [EVENT_WIDTH-1:0] data_q, head_d;
  logic                   overflow_q, frame_err_q;

  always_comb begin
    pop     = valid_q && event_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    push_ok = emit_q && (!full || pop);
    ovf_set = emit_q && full && !pop;
    count_d = count_q + CW'(push_ok) - CW'(pop);
    rd_d    = rd_q + AW'(pop);
    remain  = count_q - CW'(pop);
    // Pushing into an empty FIFO: the new event bypasses the memory.
    head_d  = (remain == '0) ? emit_data_q : mem_q[rd_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_q + AW'(push_ok);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (count_d != '0) data_q <= head_d;
      // A new error in the same cycle as clr_status wins.
      overflow_q  <= (overflow_q && !clr_status) || ovf_set;
      frame_err_q <= (frame_err_q && !clr_status) || rx_err;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= emit_data_q;
  end

  assign event_valid = valid_q;
  assign event_data  = data_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;

endmodule
